// File: rtl/descrambler_64bit.sv
// Receive-side 64b/66b self-synchronising descrambler (x^58 + x^39 + 1) with a
// one-deep registered output stage and sync-header block-lock tracking.
module descrambler_64bit #(
   parameter bit          REVERSE  = 1'b0,
   parameter logic [63:0] SEED     = 64'hFFFF_FFFF_FFFF_FFC0,
   parameter int unsigned LOCK_CNT = 64,
   parameter int unsigned BAD_CNT  = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [63:0] s_data,
   input  logic [1:0]  s_hdr,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [63:0] m_data,
   output logic [1:0]  m_hdr,
   output logic        m_hdr_err,
   output logic        m_hist_ok,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        block_lock
);

   typedef enum logic {HUNT, LOCKED} lock_state_t;

   localparam logic [9:0] LOCK_TGT = 10'(LOCK_CNT);
   localparam logic [6:0] BAD_TGT  = 7'(BAD_CNT);

   logic [63:0]  hist_q, hist_d;
   logic         hist_loaded_q, hist_loaded_d;
   logic [63:0]  m_data_q, m_data_d;
   logic [1:0]   m_hdr_q, m_hdr_d;
   logic         m_hdr_err_q, m_hdr_err_d;
   logic         m_hist_ok_q, m_hist_ok_d;
   logic         m_valid_q, m_valid_d;
   lock_state_t  state_q, state_d;
   logic [9:0]   good_cnt_q, good_cnt_d;
   logic [6:0]   bad_cnt_q, bad_cnt_d;
   logic [5:0]   win_cnt_q, win_cnt_d;

   logic [63:0]  d_word;
   logic [127:0] x_bits;
   logic [63:0]  desc_word;
   logic [63:0]  out_word;
   logic         accept;
   logic         hdr_bad;
   logic [9:0]   good_inc;
   logic [6:0]   bad_inc;

   assign s_ready = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;
   assign hdr_bad = (s_hdr == 2'b00) || (s_hdr == 2'b11);

   // X = {d, hist}: taps 39 and 58 bits back fall into hist for the low bits of d
   always_comb begin
      d_word    = '0;
      desc_word = '0;
      out_word  = '0;
      for (int k = 0; k < 64; k++) begin
         d_word[k] = REVERSE ? s_data[63-k] : s_data[k];
      end
      x_bits = {d_word, hist_q};
      for (int k = 0; k < 64; k++) begin
         desc_word[k] = x_bits[64+k] ^ x_bits[25+k] ^ x_bits[6+k];
      end
      for (int k = 0; k < 64; k++) begin
         out_word[k] = REVERSE ? desc_word[63-k] : desc_word[k];
      end
   end

   always_comb begin
      hist_d        = hist_q;
      hist_loaded_d = hist_loaded_q;
      m_data_d      = m_data_q;
      m_hdr_d       = m_hdr_q;
      m_hdr_err_d   = m_hdr_err_q;
      m_hist_ok_d   = m_hist_ok_q;
      m_valid_d     = m_valid_q;
      if (accept) begin
         hist_d        = d_word;
         hist_loaded_d = 1'b1;
         m_data_d      = out_word;
         m_hdr_d       = s_hdr;
         m_hdr_err_d   = hdr_bad;
         m_hist_ok_d   = hist_loaded_q;
         m_valid_d     = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // Counters stay bounded by the thresholds: each reaching its target clears it
   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      win_cnt_d  = win_cnt_q;
      good_inc   = good_cnt_q + 10'd1;
      bad_inc    = bad_cnt_q + {6'd0, hdr_bad};
      if (accept) begin
         case (state_q)
            HUNT: begin
               if (hdr_bad) begin
                  good_cnt_d = '0;
               end else if (good_inc >= LOCK_TGT) begin
                  state_d    = LOCKED;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
                  win_cnt_d  = '0;
               end else begin
                  good_cnt_d = good_inc;
               end
            end
            LOCKED: begin
               win_cnt_d = win_cnt_q + 6'd1;
               if (bad_inc >= BAD_TGT) begin
                  state_d    = HUNT;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
                  win_cnt_d  = '0;
               end else if (win_cnt_q == 6'd63) begin
                  bad_cnt_d = '0;
               end else begin
                  bad_cnt_d = bad_inc;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hist_q        <= SEED;
         hist_loaded_q <= 1'b0;
         m_data_q      <= '0;
         m_hdr_q       <= '0;
         m_hdr_err_q   <= 1'b0;
         m_hist_ok_q   <= 1'b0;
         m_valid_q     <= 1'b0;
         state_q       <= HUNT;
         good_cnt_q    <= '0;
         bad_cnt_q     <= '0;
         win_cnt_q     <= '0;
      end else begin
         hist_q        <= hist_d;
         hist_loaded_q <= hist_loaded_d;
         m_data_q      <= m_data_d;
         m_hdr_q       <= m_hdr_d;
         m_hdr_err_q   <= m_hdr_err_d;
         m_hist_ok_q   <= m_hist_ok_d;
         m_valid_q     <= m_valid_d;
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         bad_cnt_q     <= bad_cnt_d;
         win_cnt_q     <= win_cnt_d;
      end
   end

   assign m_data     = m_data_q;
   assign m_hdr      = m_hdr_q;
   assign m_hdr_err  = m_hdr_err_q;
   assign m_hist_ok  = m_hist_ok_q;
   assign m_valid    = m_valid_q;
   assign block_lock = (state_q == LOCKED);

endmodule

// File: tb/tb_descrambler_64bit.sv
// Directed bench for descrambler_64bit: a serial transmit-scrambler model feeds
// the block and descrambled words, handshake and lock state are checked.
module tb_descrambler_64bit;

   localparam logic [63:0] SEED_VAL = 64'hFFFF_FFFF_FFFF_FFC0;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [63:0] s_data = '0;
   logic [1:0]  s_hdr = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] m_data;
   logic [1:0]  m_hdr;
   logic        m_hdr_err;
   logic        m_hist_ok;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        block_lock;

   int          compareCount = 0;
   int          mismatchCount = 0;
   logic [63:0] txState;

   descrambler_64bit dut (
      .CLK(CLK), .RST_N(RST_N),
      .s_data(s_data), .s_hdr(s_hdr), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_hdr(m_hdr), .m_hdr_err(m_hdr_err), .m_hist_ok(m_hist_ok),
      .m_valid(m_valid), .m_ready(m_ready), .block_lock(block_lock)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Serial scrambler: each output bit depends on earlier scrambled bits 39 and 58 back
   function automatic logic [63:0] scramble(input logic [63:0] data, input logic [63:0] state);
      logic [63:0] line;
      logic [63:0] outw;
      line = state;
      outw = '0;
      for (int k = 0; k < 64; k++) begin
         outw[k] = data[k] ^ line[63-38] ^ line[63-57];
         line    = {outw[k], line[63:1]};
      end
      return outw;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] word, input logic [1:0] hdr);
      s_data  = scramble(word, txState);
      txState = s_data;
      s_hdr   = hdr;
      s_valid = 1'b1;
      @(posedge CLK);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic resetDut();
      s_valid = 1'b0;
      #2;
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   function automatic logic [1:0] goodHdr(input int i);
      return (i % 2 == 1) ? 2'b10 : 2'b01;
   endfunction

   logic [63:0] lbWords [3];
   logic [63:0] srcWords [20];
   logic [63:0] scrWords [20];
   logic        pat [6];
   logic [63:0] w;

   initial begin
      lbWords = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      #12;
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_m_data", m_data, 64'h0);
      checkOutput("rst_m_hdr", m_hdr, 2'b00);
      checkOutput("rst_m_hdr_err", m_hdr_err, 1'b0);
      checkOutput("rst_m_hist_ok", m_hist_ok, 1'b0);
      checkOutput("rst_block_lock", block_lock, 1'b0);
      checkOutput("rst_s_ready", s_ready, 1'b1);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Loopback from the matching seed
      txState = SEED_VAL;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(lbWords[i], 2'b01);
         checkOutput("lb_m_valid", m_valid, 1'b1);
         checkOutput("lb_m_data", m_data, lbWords[i]);
         checkOutput("lb_m_hist_ok", m_hist_ok, (i != 0));
         checkOutput("lb_m_hdr", m_hdr, 2'b01);
      end

      // Random transmitter state: only the first word may be wrong
      resetDut();
      txState = {$urandom, $urandom};
      for (int i = 0; i < 10; i++) begin
         w = {$urandom, $urandom};
         applyStimulus(w, 2'b10);
         checkOutput("seed_m_hist_ok", m_hist_ok, (i != 0));
         if (i != 0) checkOutput("seed_m_data", m_data, w);
      end

      // Backpressure with a cycle-level model of the output register
      resetDut();
      txState = SEED_VAL;
      for (int i = 0; i < 20; i++) begin
         srcWords[i] = {$urandom, $urandom};
         scrWords[i] = scramble(srcWords[i], txState);
         txState     = scrWords[i];
      end
      begin
         int   sent = 0;
         int   recv = 0;
         int   cyc = 0;
         int   midx = 0;
         logic mv = 1'b0;
         logic expReady, accM, xfer;
         while ((sent < 20 || mv) && cyc < 300) begin
            m_ready = pat[cyc % 6];
            s_valid = (sent < 20);
            s_data  = scrWords[(sent < 20) ? sent : 19];
            s_hdr   = 2'b10;
            #1;
            expReady = !mv || m_ready;
            checkOutput("bp_s_ready", s_ready, expReady);
            accM = s_valid && expReady;
            xfer = mv && m_ready;
            @(posedge CLK);
            #1;
            if (xfer) recv++;
            if (accM) begin
               mv   = 1'b1;
               midx = sent;
               sent++;
            end else if (xfer) begin
               mv = 1'b0;
            end
            checkOutput("bp_m_valid", m_valid, mv);
            if (mv) checkOutput("bp_m_data", m_data, srcWords[midx]);
            cyc++;
         end
         s_valid = 1'b0;
         m_ready = 1'b1;
         checkOutput("bp_received", recv, 20);
      end

      // Lock acquisition: a bad header at 63 restarts the count
      resetDut();
      txState = SEED_VAL;
      for (int i = 0; i < 63; i++) applyStimulus({$urandom, $urandom}, goodHdr(i));
      checkOutput("lock_after63", block_lock, 1'b0);
      applyStimulus({$urandom, $urandom}, 2'b11);
      checkOutput("lock_bad_hdr_err", m_hdr_err, 1'b1);
      checkOutput("lock_after_bad", block_lock, 1'b0);
      for (int i = 0; i < 64; i++) begin
         applyStimulus({$urandom, $urandom}, goodHdr(i));
         if (i == 62) checkOutput("lock_before64", block_lock, 1'b0);
      end
      checkOutput("lock_after64", block_lock, 1'b1);
      checkOutput("lock_good_hdr_err", m_hdr_err, 1'b0);
      checkOutput("lock_m_hdr", m_hdr, 2'b10);

      // 15 bad headers in each of three windows keeps lock
      for (int win = 0; win < 3; win++) begin
         for (int j = 0; j < 64; j++) begin
            if (j < 15) begin
               applyStimulus({$urandom, $urandom}, (j % 2 == 1) ? 2'b00 : 2'b11);
               checkOutput("win_hdr_err", m_hdr_err, 1'b1);
            end else begin
               applyStimulus({$urandom, $urandom}, goodHdr(j));
            end
         end
         checkOutput("win_lock_held", block_lock, 1'b1);
      end

      // 16 bad headers in one window drops lock
      for (int j = 0; j < 16; j++) begin
         applyStimulus({$urandom, $urandom}, (j % 2 == 1) ? 2'b11 : 2'b00);
         checkOutput("unlock_hdr_err", m_hdr_err, 1'b1);
         if (j == 14) checkOutput("unlock_after15", block_lock, 1'b1);
      end
      checkOutput("unlock_after16", block_lock, 1'b0);

      // Relock, stall the output, then reset asynchronously mid-cycle
      for (int i = 0; i < 64; i++) applyStimulus({$urandom, $urandom}, goodHdr(i));
      checkOutput("relock", block_lock, 1'b1);
      w = 64'hDEAD_BEEF_CAFE_F00D;
      applyStimulus(w, 2'b01);
      m_ready = 1'b0;
      @(posedge CLK);
      #1;
      checkOutput("stall_m_valid", m_valid, 1'b1);
      checkOutput("stall_m_data", m_data, w);
      checkOutput("stall_s_ready", s_ready, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      checkOutput("arst_m_valid", m_valid, 1'b0);
      checkOutput("arst_block_lock", block_lock, 1'b0);
      checkOutput("arst_m_data", m_data, 64'h0);
      @(posedge CLK);
      #1;
      RST_N   = 1'b1;
      m_ready = 1'b1;
      txState = SEED_VAL;
      w = 64'h1122_3344_5566_7788;
      applyStimulus(w, 2'b10);
      checkOutput("post_rst_m_valid", m_valid, 1'b1);
      checkOutput("post_rst_m_hist_ok", m_hist_ok, 1'b0);
      checkOutput("post_rst_m_data", m_data, w);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
